// File: rtl/wb_pkg.sv
// Shared types and helpers for the register-file writeback controller.
// Optional scoreboard build switch: WB_SCOREBOARD_EN.
package wb_pkg;

    localparam int NUM_REGS   = 32;
    localparam int WB_DATA_W  = 32;

    typedef struct packed {
        logic [4:0]           addr;
        logic [WB_DATA_W-1:0] data;
`ifdef WB_SCOREBOARD_EN
        logic                 is_load;
`endif
    } wb_entry_t;

    function automatic logic is_zero_reg(input logic [4:0] r);
        return r == 5'd0;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Dual-push / single-pop FIFO of pending register writes.
// push0 is the older of two same-cycle entries.
module wb_fifo
    import wb_pkg::*;
#(
    parameter type entry_t = wb_entry_t,
    parameter int  DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push0,
    input  entry_t                 d0,
    input  logic                   push1,
    input  entry_t                 d1,
    input  logic                   pop,
    output entry_t                 head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            w0_en, w1_en;
    entry_t          w0_dat;
    logic [AW-1:0]   w1_idx;

    always_comb begin
        w0_en    = push0 | push1;
        w1_en    = push0 & push1;
        w0_dat   = push0 ? d0 : d1;
        w1_idx   = wr_ptr_q + AW'(1);
        wr_ptr_d = wr_ptr_q + AW'(w0_en) + AW'(w1_en);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push0) + CW'(push1) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w0_en) mem_q[wr_ptr_q] <= w0_dat;
        if (w1_en) mem_q[w1_idx]   <= d1;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Register-file write-side controller: bypass mux, output stage, overflow flag
// and optional pending-load scoreboard (WB_SCOREBOARD_EN).
module rf_writeback_ctrl
    import wb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [4:0]        alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_resp_valid,
    input  logic [4:0]        ld_resp_rd,
    input  logic [DATA_W-1:0] ld_resp_data,
    input  logic              ld_issue_valid,
    input  logic [4:0]        ld_issue_rd,
    input  logic              Istall,
    input  logic              Dstall,
    output logic              wb_ready,
    output logic              RF_write,
    output logic [4:0]        write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic              wb_overflow
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    typedef struct packed {
        logic [4:0]        addr;
        logic [DATA_W-1:0] data;
`ifdef WB_SCOREBOARD_EN
        logic              is_load;
`endif
    } entry_t;

    entry_t          out_q, out_d;
    logic            out_valid_q, out_valid_d;
    logic            overflow_q, overflow_d;

    entry_t          ld_e, alu_e, in0, in1, d0, d1, head;
    logic            ld_ok, alu_ok, in0_v, in1_v;
    logic            push0, push1, pop, fifo_empty, stall;
    logic [CW-1:0]   fifo_count;

    assign stall    = Istall | Dstall;
    assign wb_ready = (CW'(BUF_DEPTH) - fifo_count) >= CW'(2);

    always_comb begin
        ld_e       = '0;
        ld_e.addr  = ld_resp_rd;
        ld_e.data  = ld_resp_data;
        alu_e      = '0;
        alu_e.addr = alu_rd;
        alu_e.data = alu_data;
`ifdef WB_SCOREBOARD_EN
        ld_e.is_load = 1'b1;
`endif
        ld_ok  = ld_resp_valid & !is_zero_reg(ld_resp_rd);
        alu_ok = alu_valid & !is_zero_reg(alu_rd);
        // Loads are ordered ahead of a same-cycle ALU result.
        in0_v  = wb_ready & (ld_ok | alu_ok);
        in0    = ld_ok ? ld_e : alu_e;
        in1_v  = wb_ready & ld_ok & alu_ok;
        in1    = alu_e;
    end

    always_comb begin
        pop         = 1'b0;
        push0       = in0_v;
        push1       = in1_v;
        d0          = in0;
        d1          = in1;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        overflow_d  = overflow_q | (!wb_ready & (ld_ok | alu_ok));
        if (!stall) begin
            if (!fifo_empty) begin
                out_valid_d = 1'b1;
                out_d       = head;
                pop         = 1'b1;
            end else if (in0_v) begin
                out_valid_d = 1'b1;
                out_d       = in0;
                push0       = in1_v;
                d0          = in1;
                push1       = 1'b0;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    wb_fifo #(
        .entry_t (entry_t),
        .DEPTH   (BUF_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push0 (push0),
        .d0    (d0),
        .push1 (push1),
        .d1    (d1),
        .pop   (pop),
        .head  (head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign RF_write    = out_valid_q;
    assign write_addr  = out_q.addr;
    assign write_data  = out_q.data;
    assign wb_overflow = overflow_q;

`ifdef WB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy_q, busy_d;

    // Set after clear so a same-register issue wins over retirement.
    always_comb begin
        busy_d = busy_q;
        if (out_valid_q && !stall && out_q.is_load)
            busy_d[out_q.addr] = 1'b0;
        if (ld_issue_valid && !is_zero_reg(ld_issue_rd))
            busy_d[ld_issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign busy_mask = busy_q;
`else
    logic unused_issue;
    assign unused_issue = ^{ld_issue_valid, ld_issue_rd};
    assign busy_mask    = '0;
`endif

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Directed self-checking bench for rf_writeback_ctrl.
// Scoreboard expectations follow the WB_SCOREBOARD_EN build switch.
module tb_rf_writeback_ctrl;

`ifdef WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif
    localparam logic [31:0] B9 = SB ? 32'h0000_0200 : 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, ld_resp_valid, ld_issue_valid;
    logic [4:0]  alu_rd, ld_resp_rd, ld_issue_rd;
    logic [31:0] alu_data, ld_resp_data;
    logic        Istall, Dstall;
    logic        wb_ready, RF_write, wb_overflow;
    logic [4:0]  write_addr;
    logic [31:0] write_data, busy_mask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_writeback_ctrl #(.DATA_W(32), .BUF_DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_valid      (alu_valid),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .ld_resp_valid  (ld_resp_valid),
        .ld_resp_rd     (ld_resp_rd),
        .ld_resp_data   (ld_resp_data),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_rd    (ld_issue_rd),
        .Istall         (Istall),
        .Dstall         (Dstall),
        .wb_ready       (wb_ready),
        .RF_write       (RF_write),
        .write_addr     (write_addr),
        .write_data     (write_data),
        .busy_mask      (busy_mask),
        .wb_overflow    (wb_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid      = 1'b0;
        ld_resp_valid  = 1'b0;
        ld_issue_valid = 1'b0;
        alu_rd         = '0;
        ld_resp_rd     = '0;
        ld_issue_rd    = '0;
        alu_data       = '0;
        ld_resp_data   = '0;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] d);
        alu_valid = 1'b1;
        alu_rd    = rd;
        alu_data  = d;
    endtask

    task automatic ld(input logic [4:0] rd, input logic [31:0] d);
        ld_resp_valid = 1'b1;
        ld_resp_rd    = rd;
        ld_resp_data  = d;
    endtask

    task automatic issue(input logic [4:0] rd);
        ld_issue_valid = 1'b1;
        ld_issue_rd    = rd;
    endtask

    initial begin
        idle();
        Istall = 1'b0;
        Dstall = 1'b0;
        rst    = 1'b1;
        repeat (2) step();
        chk("rst_we",    32'(RF_write),    32'd0);
        chk("rst_addr",  32'(write_addr),  32'd0);
        chk("rst_data",  write_data,       32'd0);
        chk("rst_busy",  busy_mask,        32'd0);
        chk("rst_ovf",   32'(wb_overflow), 32'd0);
        chk("rst_ready", 32'(wb_ready),    32'd1);
        rst = 1'b0;
        step();

        // single ALU write
        alu(5'd5, 32'h1234);
        step();
        idle();
        chk("alu_we",   32'(RF_write),   32'd1);
        chk("alu_addr", 32'(write_addr), 32'd5);
        chk("alu_data", write_data,      32'h1234);
        step();
        chk("alu_once", 32'(RF_write),   32'd0);

        // dual arrival: load first, then ALU
        ld(5'd3, 32'hAAAA);
        alu(5'd4, 32'hBBBB);
        step();
        idle();
        chk("dual1_we",   32'(RF_write),   32'd1);
        chk("dual1_addr", 32'(write_addr), 32'd3);
        chk("dual1_data", write_data,      32'hAAAA);
        step();
        chk("dual2_we",   32'(RF_write),   32'd1);
        chk("dual2_addr", 32'(write_addr), 32'd4);
        chk("dual2_data", write_data,      32'hBBBB);
        step();
        chk("dual_done",  32'(RF_write),   32'd0);

        // stall hold
        alu(5'd7, 32'h55);
        step();
        idle();
        Dstall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_we",   32'(RF_write),   32'd1);
            chk("stall_addr", 32'(write_addr), 32'd7);
            chk("stall_data", write_data,      32'h55);
        end
        Dstall = 1'b0;
        step();
        chk("stall_retire", 32'(RF_write), 32'd0);

        // scoreboard set / clear / set-wins
        issue(5'd9);
        step();
        idle();
        chk("sb_set", busy_mask, B9);
        ld(5'd9, 32'h99);
        step();
        idle();
        chk("sb_ld_addr", 32'(write_addr), 32'd9);
        chk("sb_ld_data", write_data,      32'h99);
        chk("sb_pending", busy_mask,       B9);
        step();
        chk("sb_clear", busy_mask, 32'd0);
        issue(5'd9);
        step();
        idle();
        ld(5'd9, 32'h77);
        step();
        idle();
        issue(5'd9);
        step();
        idle();
        chk("sb_set_wins", busy_mask, B9);
        ld(5'd9, 32'h78);
        step();
        idle();
        step();
        chk("sb_clear2", busy_mask, 32'd0);

        // rd = 0 discarded
        alu(5'd0, 32'hFF);
        ld(5'd0, 32'hEE);
        issue(5'd0);
        step();
        idle();
        chk("rd0_we",   32'(RF_write), 32'd0);
        chk("rd0_busy", busy_mask,     32'd0);

        // fill under stall, then overflow
        Istall = 1'b1;
        ld(5'd1, 32'h11);
        alu(5'd2, 32'h22);
        step();
        idle();
        chk("fill_ready2", 32'(wb_ready), 32'd1);
        ld(5'd3, 32'h33);
        alu(5'd4, 32'h44);
        step();
        idle();
        chk("fill_ready4", 32'(wb_ready),    32'd0);
        chk("fill_noovf",  32'(wb_overflow), 32'd0);
        chk("fill_hold",   32'(RF_write),    32'd0);
        alu(5'd5, 32'h55);
        step();
        idle();
        chk("ovf_set", 32'(wb_overflow), 32'd1);
        Istall = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("drain_we",   32'(RF_write),   32'd1);
            chk("drain_addr", 32'(write_addr), 32'(i));
            chk("drain_data", write_data,      32'(i * 'h11));
        end
        step();
        chk("drain_done", 32'(RF_write),    32'd0);
        chk("ovf_sticky", 32'(wb_overflow), 32'd1);

        // async reset mid-operation
        Istall = 1'b1;
        issue(5'd12);
        ld(5'd10, 32'hA0);
        alu(5'd11, 32'hB0);
        step();
        idle();
        Istall = 1'b0;
        alu(5'd13, 32'hC0);
        step();
        idle();
        chk("pre_rst_we", 32'(RF_write), 32'd1);
        rst = 1'b1;
        #1;
        chk("mrst_we",    32'(RF_write),    32'd0);
        chk("mrst_addr",  32'(write_addr),  32'd0);
        chk("mrst_data",  write_data,       32'd0);
        chk("mrst_busy",  busy_mask,        32'd0);
        chk("mrst_ovf",   32'(wb_overflow), 32'd0);
        chk("mrst_ready", 32'(wb_ready),    32'd1);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_we", 32'(RF_write), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_writeback_ctrl.md
# rf_writeback_ctrl

Write-side controller for the integer register file. Collects results from the ALU path and the variable-latency load path, and buffers them in a small FIFO. Drives the register file write port (`RF_write` / `write_addr` / `write_data`) one entry per un-stalled cycle and holds the port stable during Istall/Dstall. Optionally keeps a per-register pending-load scoreboard that decode uses for load-use interlock.

## Interface
Parameters:
- DATA_W, 32, register/data width
- BUF_DEPTH, 4, pending-write FIFO entries; power of 2, ≥ 2

Ports:
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-high
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  DATA_W  ALU result
- ld_resp_valid  in  1  load data returned this cycle
- ld_resp_rd  in  5  load destination register
- ld_resp_data  in  DATA_W  load data
- ld_issue_valid  in  1  load issued from EX; marks rd pending
- ld_issue_rd  in  5  issued load destination
- Istall  in  1  instruction-side stall
- Dstall  in  1  data-side stall
- wb_ready  out  1  at least 2 FIFO entries free; combinational from count
- RF_write  out  1  write strobe to register file
- write_addr  out  5  register file write address
- write_data  out  DATA_W  register file write data
- busy_mask  out  32  bit r set = load to r outstanding
- wb_overflow  out  1  sticky: input arrived while !wb_ready

## Operation
- Definition: stall = Istall | Dstall.
- Output stage is a register holding {valid, addr, data, is_load}; `RF_write` = valid; addr/data drive `write_addr`/`write_data`.
- Enqueue, every cycle, stalled or not:
  - Load response is ordered before the ALU result when both arrive together.
  - Entries with rd == 0 are discarded and never stored.
- Advance, only when !stall:
  - Output stage loads the oldest candidate: FIFO head (pop) if the FIFO is non-empty, else the first incoming entry (bypass).
  - If no candidate exists, valid ← 0.
- When stall is asserted: output stage, addr, data and `RF_write` are held unchanged. Nothing is popped.
- Two inputs with an empty FIFO and !stall: the load goes to the output stage, the ALU entry goes to the FIFO.
- If an input arrives while !wb_ready, it is dropped and `wb_overflow` is set. The flag clears only on rst.
- FIFO pointers are log2(BUF_DEPTH) bits and wrap modulo BUF_DEPTH. The count is log2(BUF_DEPTH)+1 bits.
- Scoreboard:
  - busy[ld_issue_rd] ← 1 at the edge, when ld_issue_rd ≠ 0.
  - busy[addr] ← 0 at the edge where an output-stage entry with is_load=1 retires (valid & !stall).
  - If a set and a clear hit the same register in the same cycle, set wins.
  - busy[0] is always 0.

## Timing
- Reset values: RF_write=0, write_addr=0, write_data=0, busy_mask=0, wb_overflow=0, FIFO empty (wb_ready=1).
- Latency:
  - Input at edge k with empty FIFO and !stall: `RF_write` is high after edge k (visible in cycle k+1).
  - Each stall cycle adds one cycle of latency.
  - Each older entry ahead in the FIFO adds one cycle.
- Throughput: one register write per un-stalled cycle. Input bursts of 2 per cycle are absorbed by the FIFO.
- rst mid-operation clears all buffered writes and all scoreboard bits immediately. Writes in flight are lost by design.

## Configuration
- `WB_SCOREBOARD_EN` defined: busy_mask logic as above. ld_issue_* are used. is_load is tracked per entry.
- Not defined: busy_mask is tied to 0, ld_issue_* are ignored, and the is_load field is removed. The write path is otherwise identical.

## Structure
- Package `wb_pkg`:
  - wb_entry_t struct {addr[4:0], data[DATA_W-1:0], is_load}
  - constant NUM_REGS=32
  - function is_zero_reg
- Sub-module `wb_fifo`: parameterized dual-push/single-pop FIFO of wb_entry_t, exposing count, head and pop.
- Top level holds the bypass mux, output stage, scoreboard and overflow flag.

## Test plan
- Single ALU write: alu_valid, rd=5, data=0x1234, no stall → RF_write=1, write_addr=5, write_data=0x1234 for exactly one cycle after the edge.
- Dual arrival: load rd=3 0xAAAA and ALU rd=4 0xBBBB in the same cycle → writes rd3 in cycle N+1, then rd4 in cycle N+2.
- Stall hold:
  - Stimulus: write rd=7 0x55 pending; Dstall high for 3 cycles.
  - Response: RF_write/addr/data stay 1/7/0x55 for all 3 cycles; the write retires on the first un-stalled edge.
- Scoreboard:
  - ld_issue rd=9 → busy_mask[9]=1.
  - Load response rd=9 → bit clears on the retiring edge.
  - ld_issue rd=9 on that same edge → bit stays 1.
- Boundary:
  - rd=0 inputs → no RF_write, busy_mask[0]=0.
  - Fill FIFO under stall until wb_ready=0, then push one more → wb_overflow=1.
  - Assert rst → all outputs 0, wb_ready=1.
